// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the four sensor requesters, the arbiter and the UART transmitter.
// The master side drives requests and configuration; the slave side is the arbiter.
interface uart_tx_arbiter_if;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        cfg_dnum;
    logic        cfg_snum;
    logic [1:0]  cfg_par;
    logic [1:0]  cfg_bd_rate;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_dnum;
    logic        tx_snum;
    logic [1:0]  tx_par;
    logic [1:0]  tx_bd_rate;
    logic        busy;
    logic [1:0]  grant_id;

    modport master (
        output en, req, req_data, cfg_dnum, cfg_snum, cfg_par, cfg_bd_rate,
        input  ack, tx_start, tx_data, tx_dnum, tx_snum, tx_par, tx_bd_rate, busy, grant_id
    );

    modport slave (
        input  en, req, req_data, cfg_dnum, cfg_snum, cfg_par, cfg_bd_rate,
        output ack, tx_start, tx_data, tx_dnum, tx_snum, tx_par, tx_bd_rate, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among four requesters.
// Frame length is derived from the latched configuration because the transmitter has no done flag.
module uart_tx_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        start_q, start_nxt;
    logic [3:0]  ack_q, ack_nxt;
    logic        busy_q, busy_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        dnum_q, dnum_nxt;
    logic        snum_q, snum_nxt;
    logic [1:0]  par_q, par_nxt;
    logic [1:0]  bd_q, bd_nxt;
    logic [1:0]  gid_q, gid_nxt;
    logic [1:0]  winner;
    logic [1:0]  idx;
    logic        found;

    // WAIT cycles for one frame: data bits, optional parity, stop bits plus fixed overhead.
    function automatic logic [3:0] frame_len(input logic dnum, input logic snum, input logic [1:0] par);
        logic [3:0] b;
        b = dnum ? 4'd8 : 4'd7;
        if (par == 2'b01 || par == 2'b10) b = b + 4'd1;
        return b + 4'd3 + {3'b000, snum};
    endfunction

    // Search begins just after the last winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = gid_q;
        idx    = gid_q;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = gid_q + 2'(i);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_nxt = 1'b0;
        ack_nxt   = 4'b0000;
        busy_nxt  = busy_q;
        data_nxt  = data_q;
        dnum_nxt  = dnum_q;
        snum_nxt  = snum_q;
        par_nxt   = par_q;
        bd_nxt    = bd_q;
        gid_nxt   = gid_q;
        unique case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (bus.en && found) begin
                    state_nxt = START;
                    busy_nxt  = 1'b1;
                    data_nxt  = bus.req_data[{winner, 3'b000} +: 8];
                    dnum_nxt  = bus.cfg_dnum;
                    snum_nxt  = bus.cfg_snum;
                    par_nxt   = bus.cfg_par;
                    bd_nxt    = bus.cfg_bd_rate;
                    gid_nxt   = winner;
                end
            end
            START: begin
                start_nxt = 1'b1;
                ack_nxt   = 4'b0001 << gid_q;
                busy_nxt  = 1'b1;
                cnt_nxt   = frame_len(dnum_q, snum_q, par_q);
                state_nxt = WAIT;
            end
            WAIT: begin
                busy_nxt = 1'b1;
                cnt_nxt  = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            start_q <= 1'b0;
            ack_q   <= 4'b0000;
            busy_q  <= 1'b0;
            data_q  <= 8'h00;
            dnum_q  <= 1'b0;
            snum_q  <= 1'b0;
            par_q   <= 2'b00;
            bd_q    <= 2'b00;
            gid_q   <= 2'd3;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= start_nxt;
            ack_q   <= ack_nxt;
            busy_q  <= busy_nxt;
            data_q  <= data_nxt;
            dnum_q  <= dnum_nxt;
            snum_q  <= snum_nxt;
            par_q   <= par_nxt;
            bd_q    <= bd_nxt;
            gid_q   <= gid_nxt;
        end
    end

    assign bus.tx_start   = start_q;
    assign bus.ack        = ack_q;
    assign bus.busy       = busy_q;
    assign bus.tx_data    = data_q;
    assign bus.tx_dnum    = dnum_q;
    assign bus.tx_snum    = snum_q;
    assign bus.tx_par     = par_q;
    assign bus.tx_bd_rate = bd_q;
    assign bus.grant_id   = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected grants are queued as stimulus is applied
// and checked against each tx_start pulse, including spacing, busy length and hold.
module tb_uart_tx_arbiter;
    typedef struct {
        logic [1:0] gid;
        logic [7:0] data;
        logic       dnum;
        logic       snum;
        logic [1:0] par;
        logic [1:0] bd;
        int         spacing;
        int         blen;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_start = 0;
    int   pre_busy = 0;
    int   lat;
    int   starts;
    exp_t sb[$];
    exp_t cur;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.N_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_cfg(input logic dnum, input logic snum, input logic [1:0] par);
        bus.cfg_dnum = dnum;
        bus.cfg_snum = snum;
        bus.cfg_par  = par;
    endtask

    // Expectation for the next grant: requester, frame length L, spacing from the previous start.
    task automatic push_exp(input logic [1:0] g, input int len, input int spacing);
        exp_t e;
        e.gid     = g;
        e.data    = bus.req_data[int'(g)*8 +: 8];
        e.dnum    = bus.cfg_dnum;
        e.snum    = bus.cfg_snum;
        e.par     = bus.cfg_par;
        e.bd      = bus.cfg_bd_rate;
        e.spacing = spacing;
        e.blen    = len + 1;
        sb.push_back(e);
    endtask

    task automatic wait_start(input int max, output int waited);
        int i;
        i = 0;
        pre_busy = 0;
        while (bus.tx_start !== 1'b1 && i < max) begin
            if (bus.busy === 1'b1) pre_busy++;
            else pre_busy = 0;
            @(negedge clk);
            i++;
        end
        waited = i;
        if (bus.tx_start !== 1'b1) begin
            total++;
            bad++;
            $error("FAIL start_timeout observed=0 expected=1");
        end else if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_start observed=1 expected=0");
        end else begin
            cur = sb.pop_front();
            chk("tx_data", bus.tx_data, cur.data);
            chk("ack", bus.ack, 4'b0001 << cur.gid);
            chk("grant_id", bus.grant_id, cur.gid);
            chk("tx_cfg", {bus.tx_dnum, bus.tx_snum, bus.tx_par, bus.tx_bd_rate},
                {cur.dnum, cur.snum, cur.par, cur.bd});
            if (cur.spacing > 0) chk("spacing", cyc - last_start, cur.spacing);
            last_start = cyc;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            if (n == 1) chk("pulse_width", {bus.tx_start, bus.ack}, 5'b0);
        end
        chk("busy_len", pre_busy + n, cur.blen);
        chk("hold", {bus.tx_data, bus.tx_dnum, bus.tx_snum, bus.tx_par, bus.tx_bd_rate},
            {cur.data, cur.dnum, cur.snum, cur.par, cur.bd});
    endtask

    initial begin
        rst             = 1'b1;
        bus.en          = 1'b1;
        bus.req         = 4'b0000;
        bus.req_data    = 32'h3C_7E_96_A5;
        bus.cfg_bd_rate = 2'b01;
        set_cfg(1'b1, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.tx_start, bus.ack, bus.busy, bus.tx_data, bus.tx_dnum,
            bus.tx_snum, bus.tx_par, bus.tx_bd_rate, bus.grant_id}, {20'b0, 2'b11});
        rst = 1'b0;
        @(negedge clk);

        // Fairness: all four requesting, 8N1.
        for (int i = 0; i < 5; i++) push_exp(2'(i % 4), 11, (i == 0) ? 0 : 13);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(40, lat);
            if (i == 4) bus.req = 4'b0000;
            wait_idle();
        end

        // Single request from requester 0.
        push_exp(2'd0, 11, 0);
        bus.req = 4'b0001;
        wait_start(40, lat);
        bus.req = 4'b0000;
        wait_idle();

        // Back-to-back config widths from requester 2: 7N1, 8E1, 8O2, 7O2.
        bus.cfg_bd_rate = 2'b10;
        set_cfg(1'b0, 1'b0, 2'b00);
        push_exp(2'd2, 10, 0);
        bus.req = 4'b0100;
        wait_start(40, lat);
        set_cfg(1'b1, 1'b0, 2'b10);
        push_exp(2'd2, 12, 12);
        wait_idle();
        wait_start(40, lat);
        set_cfg(1'b1, 1'b1, 2'b01);
        push_exp(2'd2, 13, 14);
        wait_idle();
        wait_start(40, lat);
        set_cfg(1'b0, 1'b1, 2'b01);
        push_exp(2'd2, 12, 15);
        wait_idle();
        wait_start(40, lat);
        bus.req = 4'b0000;
        wait_idle();

        // Config change during WAIT is ignored until the next grant.
        set_cfg(1'b1, 1'b0, 2'b00);
        push_exp(2'd3, 11, 0);
        bus.req = 4'b1000;
        wait_start(40, lat);
        set_cfg(1'b1, 1'b1, 2'b01);
        push_exp(2'd3, 13, 13);
        wait_idle();
        wait_start(40, lat);
        bus.req = 4'b0000;
        wait_idle();

        // en dropped mid-frame with requester 1 still pending.
        set_cfg(1'b1, 1'b0, 2'b00);
        push_exp(2'd1, 11, 0);
        bus.req = 4'b0010;
        wait_start(40, lat);
        bus.en = 1'b0;
        wait_idle();
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) starts++;
        end
        chk("no_grant_en_low", starts, 0);
        push_exp(2'd1, 11, 0);
        bus.en = 1'b1;
        wait_start(40, lat);
        chk("en_latency", lat, 2);
        bus.req = 4'b0000;
        wait_idle();

        // Reset five cycles into WAIT.
        push_exp(2'd2, 11, 0);
        bus.req = 4'b0100;
        wait_start(40, lat);
        bus.req = 4'b0000;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midframe_reset", {bus.tx_start, bus.ack, bus.busy, bus.tx_data, bus.tx_dnum,
            bus.tx_snum, bus.tx_par, bus.tx_bd_rate, bus.grant_id}, {20'b0, 2'b11});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_exp(2'd0, 11, 0);
        bus.req = 4'b1001;
        wait_start(40, lat);
        bus.req = 4'b1000;
        push_exp(2'd3, 11, 13);
        wait_idle();
        wait_start(40, lat);
        bus.req = 4'b0000;
        wait_idle();

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
